// File: rtl/arbitration_requestor_client_pkg.sv
// rtl/arbitration_requestor_client_pkg.sv - shared state encoding and width helper for the requestor client
package arbitration_requestor_client_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitration_requestor_client.sv
// rtl/arbitration_requestor_client.sv - requests the shared bus, streams one burst, returns the grant
module arbitration_requestor_client
    import arbitration_requestor_client_pkg::*;
#(
    parameter int  C_DATA_WIDTH    = 32,
    parameter int  C_MAX_BURST_LEN = 16,
    localparam int C_LEN_WIDTH     = clog2(C_MAX_BURST_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [C_LEN_WIDTH-1:0]  cmd_len,
    output logic                    request,
    input  logic                    grant,
    output logic                    grant_release,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [C_DATA_WIDTH-1:0] src_data,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [C_DATA_WIDTH-1:0] bus_data,
    output logic                    bus_last,
    output logic                    grant_err
);

    state_e                 state_q, state_d;
    logic [C_LEN_WIDTH-1:0] len_q, len_d;
    logic [C_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                   req_first_q, req_first_d;
    logic                   err_q, err_d;
    logic                   in_xfer;
    logic                   beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            req_first_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            req_first_q <= req_first_d;
            err_q       <= err_d;
        end
    end

    assign in_xfer       = (state_q == ST_XFER);
    assign cmd_ready     = (state_q == ST_IDLE);
    assign request       = (state_q == ST_REQ) || in_xfer;
    assign grant_release = (state_q == ST_RELEASE);
    assign bus_valid     = in_xfer & src_valid;
    assign src_ready     = in_xfer & bus_ready;
    assign bus_data      = src_data;
    assign bus_last      = in_xfer & (cnt_q == len_q);
    assign grant_err     = err_q;
    assign beat          = bus_valid & bus_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        req_first_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    err_d = 1'b1;
                end
                if (cmd_valid) begin
                    len_d       = cmd_len;
                    cnt_d       = '0;
                    req_first_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // The arbiter registers our request, so a grant seen in the first
                // REQ cycle is stale and must not start the transfer.
                if (req_first_q) begin
                    if (grant) begin
                        err_d = 1'b1;
                    end
                end else if (grant) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!grant) begin
                    err_d = 1'b1;
                end
                if (beat) begin
                    if (bus_last) begin
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/arbitration_requestor_client.md
ARBITRATION_REQUESTOR_CLIENT -- requirements
Module: arbitration_requestor_client

Interface
REQ-001 Parameter C_DATA_WIDTH, default 32, width of burst data bus.
REQ-002 Parameter C_MAX_BURST_LEN, default 16, maximum beats per burst; power of two, >= 2.
REQ-003 Derived C_LEN_WIDTH = clog2(C_MAX_BURST_LEN); cmd_len encodes beats-1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  burst command handshake.
REQ-007 cmd_len  input  C_LEN_WIDTH  beats-1 of the commanded burst.
REQ-008 request  output  1  drives this client's bit of the arbiter request vector.
REQ-009 grant  input  1  this client's grant_oh bit from the arbiter, registered there.
REQ-010 grant_release  output  1  one-cycle pulse returning the grant.
REQ-011 src_valid / src_ready / src_data  in / out / in  1 / 1 / C_DATA_WIDTH  local data source.
REQ-012 bus_valid / bus_ready / bus_data / bus_last  out / in / out / out  1 / 1 / C_DATA_WIDTH / 1  shared bus side.
REQ-013 grant_err  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states IDLE, REQ, XFER, RELEASE; request, grant_release, cmd_ready decoded from the state register only.
REQ-015 IDLE: cmd_ready=1; cmd_valid&cmd_ready captures cmd_len into len_q, clears beat counter, next state REQ.
REQ-016 REQ: request=1; advance to XFER on the first edge where grant=1 (minimum two cycles in REQ, arbiter grant is registered).
REQ-017 XFER: request=1; bus_valid=src_valid, src_ready=bus_ready, bus_data=src_data combinationally; zero added latency.
REQ-018 Outside XFER: bus_valid=0, src_ready=0, bus_last=0.
REQ-019 Beat counter (C_LEN_WIDTH bits) increments on bus_valid&bus_ready in XFER; bus_last = XFER & (count==len_q).
REQ-020 Last beat accepted (bus_valid&bus_ready&bus_last) -> RELEASE; counter never wraps past len_q.
REQ-021 RELEASE: grant_release=1, request=0, exactly one cycle, then IDLE unconditionally.
REQ-022 bus_ready low stalls counter and state; request stays high; no timeout.
REQ-023 grant_err sets when grant=1 in IDLE or REQ-entry cycle following RELEASE, or grant=0 during XFER; stays set until reset; burst continues unaffected.
REQ-024 cmd_len=0: single beat, bus_last on first beat, RELEASE next cycle.
REQ-025 cmd_valid during REQ/XFER/RELEASE ignored (cmd_ready=0); no command queueing.

Reset
REQ-026 rst_n low asynchronously forces IDLE, len_q=0, counter=0, grant_err=0; outputs request=0, grant_release=0, bus_valid=0, bus_last=0, src_ready=0, cmd_ready=1 after deassertion.
REQ-027 Reset mid-XFER abandons the burst; no grant_release issued (arbiter shares reset).
REQ-028 rst_n deassertion synchronised externally; block samples first command on first edge after release.

Structure
REQ-029 Shared package holds state enumeration and the clog2 function; C_LEN_WIDTH computed locally.
REQ-030 Single flat module; no sub-module (counter and FSM inline).

Verification
REQ-031 cmd_len=3, grant returned two cycles after request, bus_ready=1 -> 4 beats, bus_last on beat 4, grant_release one cycle later, request low in that cycle.
REQ-032 cmd_len=0 -> one beat with bus_last=1, release next cycle, IDLE with cmd_ready=1 the cycle after.
REQ-033 cmd_len=15, bus_ready toggled 1/0 -> 16 beats, counter holds on stalls, no duplicated or lost src_data values.
REQ-034 Two clients plus arbiter (C_NUM_REQUESTORS=2), both issue cmd_len=1 -> bursts serialised, never overlapping bus_valid, release precedes other client's first beat.
REQ-035 rst_n asserted during beat 2 of cmd_len=7 -> outputs zero immediately, grant_err=0, next command completes normally.
REQ-036 grant forced to 1 while IDLE -> grant_err=1 and held until rst_n low.
